// File: rtl/vote_monitor_pkg.sv
// Shared types for the triple-lane vote monitor: FSM states, lane codes and
// the width of the consecutive-disagreement run counter.
package vote_monitor_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } vm_state_e;

  typedef enum logic [1:0] {
    LANE_NONE = 2'd0,
    LANE_A    = 2'd1,
    LANE_B    = 2'd2,
    LANE_C    = 2'd3
  } lane_e;

endpackage

// File: rtl/vote_monitor_if.sv
// Lane inputs, clear request and all monitor outputs of the vote monitor.
// There is no handshake: every signal is sampled or updated on every clk edge.
interface vote_monitor_if #(parameter int CNT_W = 8);
  import vote_monitor_pkg::*;

  logic             din_a;
  logic             din_b;
  logic             din_c;
  logic             clr_err;
  logic             dout;
  logic             mismatch;
  lane_e            bad_lane;
  logic [CNT_W-1:0] err_count;
  logic             fault;
  vm_state_e        state_dbg;

  modport master (
    output din_a, din_b, din_c, clr_err,
    input  dout, mismatch, bad_lane, err_count, fault, state_dbg
  );

  modport slave (
    input  din_a, din_b, din_c, clr_err,
    output dout, mismatch, bad_lane, err_count, fault, state_dbg
  );
endinterface

// File: rtl/vote_monitor_majority3.sv
// Combinational 2-of-3 voter; also names the single lane that disagrees
// with the majority (LANE_NONE when all three agree).
module majority3
  import vote_monitor_pkg::*;
(
  input  logic  a,
  input  logic  b,
  input  logic  c,
  output logic  maj,
  output lane_e minority
);

  assign maj = (a & b) | (a & c) | (b & c);

  always_comb begin
    minority = LANE_NONE;
    if (!((a == b) && (b == c))) begin
      if (a != maj)      minority = LANE_A;
      else if (b != maj) minority = LANE_B;
      else               minority = LANE_C;
    end
  end

endmodule

// File: rtl/vote_monitor.sv
// Triple-lane vote monitor: registered majority output plus disagreement
// tracking (event counter, last bad lane, OK/SUSPECT/FAULT health FSM).
module vote_monitor
  import vote_monitor_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input logic           clk,
  input logic           rst,
  vote_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(FAULT_THRESH);

  logic             maj;
  lane_e            minority;
  logic             disagree;

  vm_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lane_e            lane_q, lane_d;
  logic             dout_q;
  logic             mismatch_q;

  majority3 u_vote (
    .a        (bus.din_a),
    .b        (bus.din_b),
    .c        (bus.din_c),
    .maj      (maj),
    .minority (minority)
  );

  assign disagree = (minority != LANE_NONE);
  assign run_inc  = run_q + RUN_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    if (bus.clr_err) begin
      // Clear wins over a coincident disagreement, which is dropped entirely.
      state_d = ST_OK;
      run_d   = '0;
      cnt_d   = '0;
      lane_d  = LANE_NONE;
    end else begin
      if (disagree) begin
        lane_d = minority;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_OK: begin
          if (disagree) begin
            state_d = ST_SUSPECT;
            run_d   = RUN_W'(1);
          end else begin
            run_d   = '0;
          end
        end
        ST_SUSPECT: begin
          if (disagree) begin
            run_d = run_inc;
            if (run_inc == THRESH) state_d = ST_FAULT;
          end else begin
            state_d = ST_OK;
            run_d   = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OK;
      run_q      <= '0;
      cnt_q      <= '0;
      lane_q     <= LANE_NONE;
      dout_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      dout_q     <= maj;
      mismatch_q <= disagree;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.bad_lane  = lane_q;
  assign bus.err_count = cnt_q;
  assign bus.fault     = (state_q == ST_FAULT);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_vote_monitor.sv
// Bench for vote_monitor: directed scenarios then random lanes/clear/reset,
// each cycle's expected outputs queued by a reference model and compared
// by an independent monitor.
module tb_vote_monitor;
  import vote_monitor_pkg::*;

  localparam int CNT_W        = 3;
  localparam int FAULT_THRESH = 4;
  localparam int W            = 1 + 1 + 2 + CNT_W + 1 + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vote_monitor_if #(.CNT_W(CNT_W)) bus ();

  vote_monitor #(.CNT_W(CNT_W), .FAULT_THRESH(FAULT_THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // reference model
  bit        m_dout;
  bit        m_mis;
  int        m_lane;
  int        m_cnt;
  int        m_run;
  vm_state_e m_state;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit a, input bit b, input bit c, input bit clr);
    int ones;
    bit dis;
    bit maj;
    int minority;
    ones     = int'(a) + int'(b) + int'(c);
    maj      = (ones >= 2);
    dis      = (ones == 1) || (ones == 2);
    minority = 0;
    if (dis) minority = (a != maj) ? 1 : (b != maj) ? 2 : 3;
    if (r) begin
      m_dout = 0; m_mis = 0; m_lane = 0; m_cnt = 0; m_run = 0; m_state = ST_OK;
      return;
    end
    m_dout = maj;
    m_mis  = dis;
    if (clr) begin
      m_state = ST_OK; m_run = 0; m_cnt = 0; m_lane = 0;
    end else if (dis) begin
      m_lane = minority;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      if (m_state != ST_FAULT) begin
        m_run   = (m_state == ST_OK) ? 1 : m_run + 1;
        m_state = (m_run >= FAULT_THRESH) ? ST_FAULT : ST_SUSPECT;
      end
    end else if (m_state != ST_FAULT) begin
      m_state = ST_OK;
      m_run   = 0;
    end
  endtask

  // driver
  task automatic drive(input bit r, input bit a, input bit b, input bit c, input bit clr);
    @(negedge clk);
    rst         = r;
    bus.din_a   = a;
    bus.din_b   = b;
    bus.din_c   = c;
    bus.clr_err = clr;
    model_step(r, a, b, c, clr);
    exp_q.push_back({m_dout, m_mis, 2'(m_lane), CNT_W'(m_cnt),
                     (m_state == ST_FAULT), m_state});
  endtask

  task automatic drive_n(input int n, input bit a, input bit b, input bit c);
    for (int i = 0; i < n; i++) drive(1'b0, a, b, c, 1'b0);
  endtask

  // monitor: compares every registered output one step after each drive
  initial begin
    logic             e_dout, e_mis, e_fault;
    logic [1:0]       e_lane, e_state;
    logic [CNT_W-1:0] e_cnt;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        {e_dout, e_mis, e_lane, e_cnt, e_fault, e_state} = exp_q.pop_front();
        check("dout",      int'(bus.dout),      int'(e_dout));
        check("mismatch",  int'(bus.mismatch),  int'(e_mis));
        check("bad_lane",  int'(bus.bad_lane),  int'(e_lane));
        check("err_count", int'(bus.err_count), int'(e_cnt));
        check("fault",     int'(bus.fault),     int'(e_fault));
        check("state",     int'(bus.state_dbg), int'(e_state));
      end
    end
  end

  // stimulus
  initial begin
    int v;
    bus.din_a   = 1'b0;
    bus.din_b   = 1'b0;
    bus.din_c   = 1'b0;
    bus.clr_err = 1'b0;

    // reset, then steady agreement
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_n(5, 1'b1, 1'b1, 1'b1);
    // single lane A glitch
    drive_n(1, 1'b0, 1'b1, 1'b1);
    drive_n(2, 1'b1, 1'b1, 1'b1);
    // persistent lane C fault, sticky through agreement
    drive_n(4, 1'b1, 1'b1, 1'b0);
    drive_n(3, 1'b1, 1'b1, 1'b1);
    // counter saturation while in FAULT
    drive_n(10, 1'b1, 1'b0, 1'b0);
    // clear coincident with a lane B disagreement
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_n(2, 1'b0, 1'b0, 1'b0);
    // reset mid-SUSPECT at run=3, then 3 more disagreements stay below threshold
    drive_n(3, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_n(3, 1'b0, 1'b0, 1'b1);
    drive_n(1, 1'b0, 1'b0, 1'b1);
    // clear with agreeing inputs
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 55) v = $urandom_range(1, 6);
      else                            v = ($urandom_range(0, 1) != 0) ? 7 : 0;
      drive(($urandom_range(0, 199) < 3), v[2], v[1], v[0],
            ($urandom_range(0, 99) < 4));
    end

    drive_n(2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vote_monitor.md
VOTE_MONITOR -- requirements
Module: vote_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the mismatch event counter.
REQ-002 Parameter FAULT_THRESH, default 4: number of consecutive mismatch cycles that declares a persistent fault; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous to clk, active-high.
REQ-005 din_a  input  1  lane A copy of the upstream data_out.
REQ-006 din_b  input  1  lane B copy of the upstream data_out.
REQ-007 din_c  input  1  lane C copy of the upstream data_out.
REQ-008 clr_err  input  1  clears the sticky fault, the counter and the lane code; sampled on clk.
REQ-009 dout  output  1  registered 2-of-3 majority of din_a/b/c.
REQ-010 mismatch  output  1  registered; high when the lanes disagreed in the previous cycle.
REQ-011 bad_lane  output  2  registered code of the last disagreeing lane: 0 none, 1 A, 2 B, 3 C.
REQ-012 err_count  output  CNT_W  mismatch cycles seen since reset or clear; saturating.
REQ-013 fault  output  1  high while the FSM is in FAULT.

Function
REQ-014 dout SHALL equal maj(din_a,din_b,din_c), sampled at the previous clk edge; latency exactly 1 cycle; unaffected by clr_err and by FSM state.
REQ-015 Disagreement SHALL mean that the three inputs are not all equal; mismatch SHALL register that condition with 1-cycle latency.
REQ-016 On a disagreement, bad_lane SHALL register the single minority lane (1/2/3); it SHALL hold its value on agreeing cycles.
REQ-017 err_count SHALL increment by 1 on each disagreement cycle and SHALL saturate at 2^CNT_W-1, with no wrap-around.
REQ-018 FSM states: OK, SUSPECT, FAULT; an internal run counter (8 bits) SHALL count consecutive disagreement cycles.
REQ-019 OK: on a disagreement go to SUSPECT with run=1; otherwise stay with run=0.
REQ-020 SUSPECT: on a disagreement set run=run+1, and go to FAULT when run+1 reaches FAULT_THRESH; on agreement go to OK with run=0.
REQ-021 FAULT SHALL be sticky regardless of the inputs and SHALL exit only on clr_err or rst.
REQ-022 clr_err SHALL have priority over a coincident disagreement: next state OK, run=0, err_count=0, bad_lane=0, and the coincident disagreement is discarded; mismatch still reflects it.
REQ-023 fault SHALL assert in the first cycle after the edge that enters FAULT.
REQ-024 An illegal state encoding SHALL recover to OK on the next edge.

Reset
REQ-025 rst high at an edge SHALL force dout=0, mismatch=0, bad_lane=0, err_count=0, fault=0, state=OK, run=0; it SHALL override clr_err and all inputs.
REQ-026 Asserting rst mid-SUSPECT or mid-FAULT SHALL discard the whole history; the first post-reset disagreement SHALL restart at run=1.

Structure
REQ-027 A shared package SHALL hold the state enum (OK/SUSPECT/FAULT), the bad_lane codes (LANE_NONE/A/B/C) and the run-counter width constant.
REQ-028 The voter SHALL be one combinational sub-module majority3 (inputs a, b, c; outputs maj and the 2-bit minority lane code), instantiated once.
REQ-029 The block SHALL contain no latches; all registers SHALL sit in one clocked process on clk.

Verification
REQ-030 Drive rst for 2 cycles, then hold a=b=c=1 for 5 cycles -> dout=1 from cycle 1, mismatch=0, err_count=0, fault=0.
REQ-031 Drive a=0,b=1,c=1 for one cycle, then agreement -> dout=1, mismatch pulses once, bad_lane=1, err_count=1, state OK->SUSPECT->OK, fault=0.
REQ-032 Hold c=0 against a=b=1 for 4 cycles with FAULT_THRESH=4 -> fault=1 after the 4th edge, bad_lane=3, err_count=4; fault stays high after agreement resumes.
REQ-033 Use CNT_W=3 and 10 disagreement cycles -> err_count stops at 7.
REQ-034 Assert clr_err in FAULT on the same cycle as b=0,a=c=1 -> state OK, err_count=0, bad_lane=0, fault=0, mismatch=1.
REQ-035 Assert rst during SUSPECT with run=3 -> all outputs 0; after 3 following disagreement cycles (FAULT_THRESH=4), fault=0.
